// File: rtl/i_mem_loader.sv
// Byte-stream program loader: receives a length/word/checksum frame and writes it
// into instruction memory while holding the CPU off.
module i_mem_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t      state, state_next;
  logic        start;
  logic        xfer;
  logic        csum_ok;
  logic [8:0]  remaining;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;

  // Stream handshake: a byte moves on a cycle where in_valid && in_ready are both
  // high; in_ready decodes from state alone and in_data is ignored otherwise.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    start      = 1'b0;
    csum_ok    = (in_data == csum);
    case (state)
      S_IDLE, S_ERR: begin
        if (load_req) begin
          state_next = S_LEN;
          start      = 1'b1;
        end
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = (remaining == 9'd1) ? S_CHK : S_HI;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_next = csum_ok ? S_DONE : S_ERR;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign xfer      = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= BASE_ADDR;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      hi_byte   <= '0;
      csum      <= '0;
    end else begin
      // Registered strobe: high exactly while the FSM sits in WRITE.
      mem_we <= (state_next == S_WRITE);
      if (start) begin
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        mem_addr <= BASE_ADDR;
        csum     <= '0;
      end
      case (state)
        S_LEN: begin
          // A length byte of zero stands for a full 256-word image.
          if (xfer) remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
        end
        S_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            csum    <= csum ^ in_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            mem_data <= {hi_byte, in_data};
            csum     <= csum ^ in_data;
          end
        end
        S_WRITE: begin
          mem_addr  <= mem_addr + 1'b1;
          remaining <= remaining - 9'd1;
        end
        S_CHK: begin
          if (xfer) begin
            if (csum_ok) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_loader.sv
// Directed bench for i_mem_loader: drives load frames and checks every memory write
// against an expected-write queue, plus status outputs at key points.
module tb_i_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  i_mem_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          xfer_cnt  = 0;
  logic        cont_valid = 1'b0;
  logic [7:0]  exp_addr;
  logic [7:0]  exp_csum;
  logic [23:0] exp_q[$];
  logic [15:0] frame_w[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) xfer_cnt++;
      if (mem_we) begin
        check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        check("hold_during_write", {31'd0, cpu_hold}, 32'd1);
        n_asserts++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL extra_write observed=%0h expected=none", {mem_addr, mem_data});
        end
        if (exp_q.size() != 0) check("write_addr_data", {8'd0, mem_addr, mem_data}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    exp_addr = 8'h00;
    exp_csum = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!cont_valid) begin
      in_valid = 1'b0;
      tick(1);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 8'd1;
    exp_csum = exp_csum ^ w[15:8] ^ w[7:0];
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic run_frame(input logic bad);
    int n;
    n = frame_w.size();
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) send_word(frame_w[i]);
    send_byte(bad ? (exp_csum ^ 8'h01) : exp_csum);
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_err"}, {31'd0, err}, {31'd0, e});
    check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  initial begin
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    exp_addr = 8'h00; exp_csum = 8'h00;
    tick(2);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'h00);
    check("rst_mem_data", {16'd0, mem_data}, 32'h0000);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);

    // Case 1: two-word frame with idle gaps between bytes.
    tick(1);
    pulse_load();
    check("c1_hold_after_req", {31'd0, cpu_hold}, 32'd1);
    frame_w = '{16'h1234, 16'hABCD};
    run_frame(1'b0);
    check("c1_csum_model", {24'd0, exp_csum}, 32'h40);
    check("c1_q_empty", exp_q.size(), 32'd0);
    check_status("c1", 1'b1, 1'b0, 1'b0);
    tick(2);
    check("c1_done_sticky", {31'd0, done}, 32'd1);

    // Case 2: corrupt checksum, ERR holds, then a good frame recovers.
    pulse_load();
    check("c2_done_cleared", {31'd0, done}, 32'd0);
    run_frame(1'b1);
    check("c2_q_empty", exp_q.size(), 32'd0);
    check_status("c2", 1'b0, 1'b1, 1'b1);
    tick(3);
    check_status("c2_stay", 1'b0, 1'b1, 1'b1);
    check("c2_ready_in_err", {31'd0, in_ready}, 32'd0);
    pulse_load();
    check("c2_err_cleared", {31'd0, err}, 32'd0);
    run_frame(1'b0);
    check_status("c2_recover", 1'b1, 1'b0, 1'b0);
    tick(1);

    // Case 3: in_valid held high continuously through the frame.
    pulse_load();
    cont_valid = 1'b1;
    xfer_cnt = 0;
    run_frame(1'b0);
    cont_valid = 1'b0;
    tick(2);
    check("c3_xfer_count", xfer_cnt, 32'd6);
    check("c3_q_empty", exp_q.size(), 32'd0);
    check_status("c3", 1'b1, 1'b0, 1'b0);

    // Case 4: length 0 means 256 words; address wraps after the last write.
    pulse_load();
    frame_w.delete();
    for (int k = 0; k < 256; k++) frame_w.push_back({k[7:0], k[7:0]});
    run_frame(1'b0);
    check("c4_csum_model", {24'd0, exp_csum}, 32'h00);
    check("c4_q_empty", exp_q.size(), 32'd0);
    check("c4_addr_wrap", {24'd0, mem_addr}, 32'h00);
    check_status("c4", 1'b1, 1'b0, 1'b0);
    tick(1);

    // Case 5: reset after the first word of a three-word frame.
    pulse_load();
    send_byte(8'h03);
    send_word(16'h5A5A);
    tick(1);
    check("c5_q_empty_pre_rst", exp_q.size(), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("c5_in_ready", {31'd0, in_ready}, 32'd0);
    check("c5_mem_we", {31'd0, mem_we}, 32'd0);
    check("c5_mem_addr", {24'd0, mem_addr}, 32'h00);
    check("c5_mem_data", {16'd0, mem_data}, 32'h0000);
    check("c5_state", {29'd0, dbg_state}, 32'd0);
    check_status("c5_rst", 1'b0, 1'b0, 1'b0);
    tick(1);
    pulse_load();
    frame_w = '{16'h0F1E};
    run_frame(1'b0);
    check("c5_q_empty", exp_q.size(), 32'd0);
    check_status("c5_restart", 1'b1, 1'b0, 1'b0);
    tick(1);

    // Case 6: load_req pulses in HI and CHK are ignored.
    pulse_load();
    send_byte(8'h02);
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    check("c6_state_hi", {29'd0, dbg_state}, 32'd2);
    send_word(16'h1234);
    send_word(16'hABCD);
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    check("c6_state_chk", {29'd0, dbg_state}, 32'd5);
    send_byte(exp_csum);
    check("c6_q_empty", exp_q.size(), 32'd0);
    check_status("c6", 1'b1, 1'b0, 1'b0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
